// File: rtl/dcache_ctrl.sv
// dcache_ctrl -- data-cache controller, responder end of the LSQ-to-Dcache link.
//
// Purpose:
//   Direct-mapped, write-through data cache of 2**IDX_BITS quadword lines.
//   Loads are accepted one per cycle into a small load queue (MSHR). Each load
//   completes either as a hit, as a forward from the store buffer, or through
//   the tagged split-transaction memory port. Retired stores go into a circular
//   store buffer that drains to memory ahead of load misses. Completed loads
//   are written back on the second PRF/CDB write port.
//
// Ports:
//   clock, reset                 clock, asynchronous active-high reset
//   Dcache_rd_mem/addr/pr/ar     load request and its destination registers
//   Dcache_wr_mem/st_addr/value  retired store
//   Dcache_avail                 a load can be accepted this cycle
//   cdb_*, prf_pr_*              load completion broadcast / PRF write
//   proc2mem_command/addr/data   memory request (0 NONE, 1 LOAD, 2 STORE)
//   mem2proc_response            nonzero = request accepted, value is its tag
//   mem2proc_data/tag            fill data, tagged (tag 0 = no fill)
module dcache_ctrl #(
  parameter int N_MSHR   = 4,
  parameter int N_STB    = 4,
  parameter int IDX_BITS = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Dcache_rd_mem,
  input  logic        Dcache_wr_mem,
  input  logic [63:0] Dcache_addr,
  input  logic [6:0]  Dcache_pr_idx,
  input  logic [4:0]  Dcache_ar_idx,
  input  logic [63:0] Dcache_st_addr,
  input  logic [63:0] Dcache_st_value,
  output logic        Dcache_avail,
  output logic        cdb_complete,
  output logic [6:0]  cdb_prf_pr_idx,
  output logic [4:0]  cdb_ar_idx,
  output logic        prf_pr_wr_enable,
  output logic [63:0] prf_pr_value,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag
);

  localparam int QA_W    = 61;
  localparam int TAG_W   = QA_W - IDX_BITS;
  localparam int N_LINES = 1 << IDX_BITS;
  localparam int MI_W    = (N_MSHR > 1) ? $clog2(N_MSHR) : 1;
  localparam int SI_W    = (N_STB > 1) ? $clog2(N_STB) : 1;
  localparam int SC_W    = $clog2(N_STB + 1);

  typedef enum logic [1:0] {S_EMPTY, S_WAIT_ISSUE, S_WAIT_MEM, S_DONE} mshr_state_e;
  typedef enum logic [1:0] {CMD_NONE = 2'd0, CMD_LOAD = 2'd1, CMD_STORE = 2'd2} mem_cmd_e;

  // Cache lines
  logic              r_lineValid [N_LINES];
  logic [TAG_W-1:0]  r_lineTag   [N_LINES];
  logic [63:0]       r_lineData  [N_LINES];

  // Load queue entries
  mshr_state_e       r_state     [N_MSHR];
  logic [6:0]        r_pr        [N_MSHR];
  logic [4:0]        r_ar        [N_MSHR];
  logic [QA_W-1:0]   r_qaddr     [N_MSHR];
  logic [3:0]        r_memTag    [N_MSHR];
  logic [63:0]       r_data      [N_MSHR];
  logic              r_merged    [N_MSHR];
  logic [63:0]       r_mergeData [N_MSHR];

  mshr_state_e       w_nState     [N_MSHR];
  logic [6:0]        w_nPr        [N_MSHR];
  logic [4:0]        w_nAr        [N_MSHR];
  logic [QA_W-1:0]   w_nQaddr     [N_MSHR];
  logic [3:0]        w_nMemTag    [N_MSHR];
  logic [63:0]       w_nData      [N_MSHR];
  logic              w_nMerged    [N_MSHR];
  logic [63:0]       w_nMergeData [N_MSHR];

  // Store buffer
  logic [QA_W-1:0]   r_stbAddr [N_STB];
  logic [63:0]       r_stbData [N_STB];
  logic [SI_W-1:0]   r_stbHead;
  logic [SI_W-1:0]   r_stbTail;
  logic [SC_W-1:0]   r_stbCount;

  logic [QA_W-1:0]   w_ldQaddr;
  logic [QA_W-1:0]   w_stQaddr;
  logic              w_stbFull;
  logic              w_stbEmpty;
  logic              w_anyEmpty;
  logic [MI_W-1:0]   w_allocIdx;
  logic              w_accept;
  logic              w_stPush;
  logic              w_stPop;
  logic              w_ldHit;
  logic              w_fwdHit;
  logic [63:0]       w_fwdData;
  logic [SI_W-1:0]   w_slot;
  logic              w_cplValid;
  logic [MI_W-1:0]   w_cplIdx;
  logic              w_issValid;
  logic [MI_W-1:0]   w_issIdx;
  logic              w_issueAck;
  logic              w_fillValid;
  logic [MI_W-1:0]   w_fillIdx;
  logic [63:0]       w_fillData;
  logic [QA_W-1:0]   w_fillQaddr;
  logic              w_stHit;

  assign w_ldQaddr  = Dcache_addr[63:3];
  assign w_stQaddr  = Dcache_st_addr[63:3];
  assign w_stbFull  = (r_stbCount == SC_W'(N_STB));
  assign w_stbEmpty = (r_stbCount == '0);

  assign Dcache_avail = w_anyEmpty & ~w_stbFull;
  assign w_accept     = Dcache_rd_mem & Dcache_avail;
  assign w_stPush     = Dcache_wr_mem & ~w_stbFull;
  assign w_stPop      = ~w_stbEmpty & (mem2proc_response != 4'd0);
  assign w_issueAck   = w_stbEmpty & w_issValid & (mem2proc_response != 4'd0);

  assign w_ldHit = r_lineValid[w_ldQaddr[IDX_BITS-1:0]] &&
                   (r_lineTag[w_ldQaddr[IDX_BITS-1:0]] == w_ldQaddr[QA_W-1:IDX_BITS]);

  // Priority pickers over the load queue: lowest index wins, so loops run
  // downward and the last assignment is the lowest matching entry.
  always_comb begin
    w_anyEmpty  = 1'b0;
    w_allocIdx  = '0;
    w_cplValid  = 1'b0;
    w_cplIdx    = '0;
    w_issValid  = 1'b0;
    w_issIdx    = '0;
    w_fillValid = 1'b0;
    w_fillIdx   = '0;
    for (int i = N_MSHR - 1; i >= 0; i--) begin
      if (r_state[i] == S_EMPTY) begin
        w_anyEmpty = 1'b1;
        w_allocIdx = MI_W'(i);
      end
      if (r_state[i] == S_DONE) begin
        w_cplValid = 1'b1;
        w_cplIdx   = MI_W'(i);
      end
      if (r_state[i] == S_WAIT_ISSUE) begin
        w_issValid = 1'b1;
        w_issIdx   = MI_W'(i);
      end
      if ((r_state[i] == S_WAIT_MEM) && (mem2proc_tag != 4'd0) && (r_memTag[i] == mem2proc_tag)) begin
        w_fillValid = 1'b1;
        w_fillIdx   = MI_W'(i);
      end
    end
  end

  assign w_fillData  = r_merged[w_fillIdx] ? r_mergeData[w_fillIdx] : mem2proc_data;
  assign w_fillQaddr = r_qaddr[w_fillIdx];

  // A store hits against the line as it will look after this cycle's fill,
  // so a fill and a store to the same line leave the store data in the cache.
  always_comb begin
    if (w_fillValid && (w_fillQaddr[IDX_BITS-1:0] == w_stQaddr[IDX_BITS-1:0])) begin
      w_stHit = (w_fillQaddr[QA_W-1:IDX_BITS] == w_stQaddr[QA_W-1:IDX_BITS]);
    end else begin
      w_stHit = r_lineValid[w_stQaddr[IDX_BITS-1:0]] &&
                (r_lineTag[w_stQaddr[IDX_BITS-1:0]] == w_stQaddr[QA_W-1:IDX_BITS]);
    end
  end

  // Store-buffer forwarding: walk from oldest to youngest so the youngest
  // matching store is the one left in w_fwdData.
  always_comb begin
    w_fwdHit  = 1'b0;
    w_fwdData = '0;
    w_slot    = '0;
    for (int i = 0; i < N_STB; i++) begin
      w_slot = SI_W'((int'(r_stbHead) + i) % N_STB);
      if ((SC_W'(i) < r_stbCount) && (r_stbAddr[w_slot] == w_ldQaddr)) begin
        w_fwdHit  = 1'b1;
        w_fwdData = r_stbData[w_slot];
      end
    end
  end

  // Next state of every load-queue entry. Events are applied in the order
  // completion, issue, fill, store, allocation; a later event overrides an
  // earlier one, which gives "fill then store" and lets a store that catches
  // a load in the middle of being issued finish it directly (its eventual
  // fill then matches nothing and is dropped).
  always_comb begin
    for (int i = 0; i < N_MSHR; i++) begin
      w_nState[i]     = r_state[i];
      w_nPr[i]        = r_pr[i];
      w_nAr[i]        = r_ar[i];
      w_nQaddr[i]     = r_qaddr[i];
      w_nMemTag[i]    = r_memTag[i];
      w_nData[i]      = r_data[i];
      w_nMerged[i]    = r_merged[i];
      w_nMergeData[i] = r_mergeData[i];

      if (w_cplValid && (w_cplIdx == MI_W'(i))) begin
        w_nState[i] = S_EMPTY;
      end

      if (w_issueAck && (w_issIdx == MI_W'(i))) begin
        w_nState[i]  = S_WAIT_MEM;
        w_nMemTag[i] = mem2proc_response;
      end

      if (w_fillValid && (w_fillIdx == MI_W'(i))) begin
        w_nState[i] = S_DONE;
        w_nData[i]  = w_fillData;
      end

      if (w_stPush && (r_qaddr[i] == w_stQaddr)) begin
        if (r_state[i] == S_WAIT_ISSUE) begin
          w_nState[i] = S_DONE;
          w_nData[i]  = Dcache_st_value;
        end else if (r_state[i] == S_WAIT_MEM) begin
          if (w_fillValid && (w_fillIdx == MI_W'(i))) begin
            w_nData[i] = Dcache_st_value;
          end else begin
            w_nMerged[i]    = 1'b1;
            w_nMergeData[i] = Dcache_st_value;
          end
        end
      end

      // A retired store arriving with the load is older than it, so it is
      // forwarded just like a buffered store.
      if (w_accept && (w_allocIdx == MI_W'(i))) begin
        w_nPr[i]     = Dcache_pr_idx;
        w_nAr[i]     = Dcache_ar_idx;
        w_nQaddr[i]  = w_ldQaddr;
        w_nMerged[i] = 1'b0;
        if (w_stPush && (w_stQaddr == w_ldQaddr)) begin
          w_nState[i] = S_DONE;
          w_nData[i]  = Dcache_st_value;
        end else if (w_fwdHit) begin
          w_nState[i] = S_DONE;
          w_nData[i]  = w_fwdData;
        end else if (w_ldHit) begin
          w_nState[i] = S_DONE;
          w_nData[i]  = r_lineData[w_ldQaddr[IDX_BITS-1:0]];
        end else begin
          w_nState[i] = S_WAIT_ISSUE;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_MSHR; i++) begin
        r_state[i]     <= S_EMPTY;
        r_pr[i]        <= '0;
        r_ar[i]        <= '0;
        r_qaddr[i]     <= '0;
        r_memTag[i]    <= '0;
        r_data[i]      <= '0;
        r_merged[i]    <= 1'b0;
        r_mergeData[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_MSHR; i++) begin
        r_state[i]     <= w_nState[i];
        r_pr[i]        <= w_nPr[i];
        r_ar[i]        <= w_nAr[i];
        r_qaddr[i]     <= w_nQaddr[i];
        r_memTag[i]    <= w_nMemTag[i];
        r_data[i]      <= w_nData[i];
        r_merged[i]    <= w_nMerged[i];
        r_mergeData[i] <= w_nMergeData[i];
      end
    end
  end

  // Line valid bits are the only cache state that needs clearing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_LINES; i++) begin
        r_lineValid[i] <= 1'b0;
      end
    end else if (w_fillValid) begin
      r_lineValid[w_fillQaddr[IDX_BITS-1:0]] <= 1'b1;
    end
  end

  // Fill is written first; a same-cycle store hit to that line overrides it.
  always_ff @(posedge clock) begin
    if (w_fillValid) begin
      r_lineTag[w_fillQaddr[IDX_BITS-1:0]]  <= w_fillQaddr[QA_W-1:IDX_BITS];
      r_lineData[w_fillQaddr[IDX_BITS-1:0]] <= w_fillData;
    end
    if (w_stPush && w_stHit) begin
      r_lineData[w_stQaddr[IDX_BITS-1:0]] <= Dcache_st_value;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stbHead  <= '0;
      r_stbTail  <= '0;
      r_stbCount <= '0;
    end else begin
      if (w_stPush) begin
        r_stbTail <= (r_stbTail == SI_W'(N_STB - 1)) ? '0 : r_stbTail + 1'b1;
      end
      if (w_stPop) begin
        r_stbHead <= (r_stbHead == SI_W'(N_STB - 1)) ? '0 : r_stbHead + 1'b1;
      end
      if (w_stPush && !w_stPop) begin
        r_stbCount <= r_stbCount + 1'b1;
      end else if (!w_stPush && w_stPop) begin
        r_stbCount <= r_stbCount - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_stPush) begin
      r_stbAddr[r_stbTail] <= w_stQaddr;
      r_stbData[r_stbTail] <= Dcache_st_value;
    end
  end

  // Completion port and memory request are driven from registered state only.
  always_comb begin
    cdb_complete     = w_cplValid;
    prf_pr_wr_enable = w_cplValid;
    cdb_prf_pr_idx   = '0;
    cdb_ar_idx       = '0;
    prf_pr_value     = '0;
    if (w_cplValid) begin
      cdb_prf_pr_idx = r_pr[w_cplIdx];
      cdb_ar_idx     = r_ar[w_cplIdx];
      prf_pr_value   = r_data[w_cplIdx];
    end

    proc2mem_command = CMD_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (!w_stbEmpty) begin
      proc2mem_command = CMD_STORE;
      proc2mem_addr    = {r_stbAddr[r_stbHead], 3'b000};
      proc2mem_data    = r_stbData[r_stbHead];
    end else if (w_issValid) begin
      proc2mem_command = CMD_LOAD;
      proc2mem_addr    = {r_qaddr[w_issIdx], 3'b000};
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl -- self-checking bench for dcache_ctrl.
//
// Purpose:
//   Directed load/store/fill sequences. Expected load completions are pushed
//   into a scoreboard queue when the stimulus is issued; a monitor pops and
//   compares on every cycle the DUT broadcasts a completion. Memory-port and
//   availability outputs are checked directly after each stimulus cycle.
module tb_dcache_ctrl;

  logic        clock;
  logic        reset;
  logic        Dcache_rd_mem;
  logic        Dcache_wr_mem;
  logic [63:0] Dcache_addr;
  logic [6:0]  Dcache_pr_idx;
  logic [4:0]  Dcache_ar_idx;
  logic [63:0] Dcache_st_addr;
  logic [63:0] Dcache_st_value;
  logic        Dcache_avail;
  logic        cdb_complete;
  logic [6:0]  cdb_prf_pr_idx;
  logic [4:0]  cdb_ar_idx;
  logic        prf_pr_wr_enable;
  logic [63:0] prf_pr_value;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;

  typedef struct packed {
    logic [6:0]  pr;
    logic [4:0]  ar;
    logic [63:0] value;
  } cpl_t;

  cpl_t expQ[$];
  cpl_t expItem;
  int   errors  = 0;
  int   checks  = 0;
  int   sbCount = 0;

  dcache_ctrl dut (
    .clock             (clock),
    .reset             (reset),
    .Dcache_rd_mem     (Dcache_rd_mem),
    .Dcache_wr_mem     (Dcache_wr_mem),
    .Dcache_addr       (Dcache_addr),
    .Dcache_pr_idx     (Dcache_pr_idx),
    .Dcache_ar_idx     (Dcache_ar_idx),
    .Dcache_st_addr    (Dcache_st_addr),
    .Dcache_st_value   (Dcache_st_value),
    .Dcache_avail      (Dcache_avail),
    .cdb_complete      (cdb_complete),
    .cdb_prf_pr_idx    (cdb_prf_pr_idx),
    .cdb_ar_idx        (cdb_ar_idx),
    .prf_pr_wr_enable  (prf_pr_wr_enable),
    .prf_pr_value      (prf_pr_value),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs, lets the rising edge take them, and returns at
  // the following falling edge where registered outputs are stable.
  task automatic applyStimulus(input logic rd, input logic [63:0] addr, input logic [6:0] pr,
                               input logic [4:0] ar, input logic wr, input logic [63:0] stAddr,
                               input logic [63:0] stVal, input logic [3:0] resp,
                               input logic [3:0] ftag, input logic [63:0] fdata);
    Dcache_rd_mem     = rd;
    Dcache_addr       = addr;
    Dcache_pr_idx     = pr;
    Dcache_ar_idx     = ar;
    Dcache_wr_mem     = wr;
    Dcache_st_addr    = stAddr;
    Dcache_st_value   = stVal;
    mem2proc_response = resp;
    mem2proc_tag      = ftag;
    mem2proc_data     = fdata;
    @(negedge clock);
  endtask

  task automatic loadOp(input logic [63:0] addr, input logic [6:0] pr, input logic [4:0] ar,
                        input logic [3:0] resp);
    applyStimulus(1'b1, addr, pr, ar, 1'b0, 64'd0, 64'd0, resp, 4'd0, 64'd0);
  endtask

  task automatic storeOp(input logic [63:0] stAddr, input logic [63:0] stVal);
    applyStimulus(1'b0, 64'd0, 7'd0, 5'd0, 1'b1, stAddr, stVal, 4'd0, 4'd0, 64'd0);
  endtask

  task automatic respOp(input logic [3:0] resp);
    applyStimulus(1'b0, 64'd0, 7'd0, 5'd0, 1'b0, 64'd0, 64'd0, resp, 4'd0, 64'd0);
  endtask

  task automatic fillOp(input logic [3:0] ftag, input logic [63:0] fdata);
    applyStimulus(1'b0, 64'd0, 7'd0, 5'd0, 1'b0, 64'd0, 64'd0, 4'd0, ftag, fdata);
  endtask

  task automatic expectCpl(input logic [6:0] pr, input logic [4:0] ar, input logic [63:0] value);
    expQ.push_back('{pr: pr, ar: ar, value: value});
  endtask

  // Completion monitor: every broadcast must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset && cdb_complete === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_cdb: got pr %0d ar %0d value 0x%0h, expected no completion",
                 cdb_prf_pr_idx, cdb_ar_idx, prf_pr_value);
      end else begin
        expItem = expQ.pop_front();
        checkOutput("cdb_pr", 64'(cdb_prf_pr_idx), 64'(expItem.pr));
        checkOutput("cdb_ar", 64'(cdb_ar_idx), 64'(expItem.ar));
        checkOutput("cdb_value", prf_pr_value, expItem.value);
        checkOutput("prf_wr_enable", 64'(prf_pr_wr_enable), 64'd1);
      end
    end
  end

  // Bench-side store-buffer occupancy, used to catch pushes into a full buffer.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      sbCount = 0;
    end else begin
      assert (!(Dcache_wr_mem && sbCount >= 4)) else $error("[TB] store pushed while buffer full");
      sbCount = sbCount + (Dcache_wr_mem ? 1 : 0)
                - ((proc2mem_command == 2'd2 && mem2proc_response != 4'd0) ? 1 : 0);
    end
  end

  initial begin
    reset = 1'b1;
    Dcache_rd_mem = 1'b0; Dcache_wr_mem = 1'b0; Dcache_addr = '0; Dcache_pr_idx = '0;
    Dcache_ar_idx = '0; Dcache_st_addr = '0; Dcache_st_value = '0;
    mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Reset state
    checkOutput("reset_avail", 64'(Dcache_avail), 64'd1);
    checkOutput("reset_cdb", 64'(cdb_complete), 64'd0);
    checkOutput("reset_prf_we", 64'(prf_pr_wr_enable), 64'd0);
    checkOutput("reset_cmd", 64'(proc2mem_command), 64'd0);
    checkOutput("reset_addr", proc2mem_addr, 64'd0);

    // Cold miss, fill, then hit on the same address
    loadOp(64'h1000, 7'd12, 5'd3, 4'd0);
    checkOutput("cold_cmd", 64'(proc2mem_command), 64'd1);
    checkOutput("cold_addr", proc2mem_addr, 64'h1000);
    respOp(4'd5);
    checkOutput("cold_cmd_after_resp", 64'(proc2mem_command), 64'd0);
    expectCpl(7'd12, 5'd3, 64'hAB);
    fillOp(4'd5, 64'hAB);
    checkOutput("miss_cpl_latency", 64'(cdb_complete), 64'd1);
    expectCpl(7'd20, 5'd4, 64'hAB);
    loadOp(64'h1000, 7'd20, 5'd4, 4'd0);
    checkOutput("hit_cpl_latency", 64'(cdb_complete), 64'd1);
    checkOutput("hit_no_mem", 64'(proc2mem_command), 64'd0);

    // Four misses with memory refusing: queue full
    loadOp(64'h4000, 7'd30, 5'd10, 4'd0);
    loadOp(64'h4008, 7'd31, 5'd11, 4'd0);
    loadOp(64'h4010, 7'd32, 5'd12, 4'd0);
    loadOp(64'h4018, 7'd33, 5'd13, 4'd0);
    checkOutput("full_avail", 64'(Dcache_avail), 64'd0);
    checkOutput("full_cmd", 64'(proc2mem_command), 64'd1);
    checkOutput("full_addr0", proc2mem_addr, 64'h4000);
    respOp(4'd1);
    checkOutput("full_avail_after_issue", 64'(Dcache_avail), 64'd0);
    checkOutput("full_addr1", proc2mem_addr, 64'h4008);
    respOp(4'd2);
    checkOutput("full_addr2", proc2mem_addr, 64'h4010);
    respOp(4'd3);
    checkOutput("full_addr3", proc2mem_addr, 64'h4018);
    respOp(4'd4);
    checkOutput("all_issued_cmd", 64'(proc2mem_command), 64'd0);
    checkOutput("all_issued_avail", 64'(Dcache_avail), 64'd0);
    expectCpl(7'd30, 5'd10, 64'h1111);
    fillOp(4'd1, 64'h1111);
    checkOutput("done_not_free_avail", 64'(Dcache_avail), 64'd0);
    expectCpl(7'd31, 5'd11, 64'h2222);
    fillOp(4'd2, 64'h2222);
    checkOutput("freed_avail", 64'(Dcache_avail), 64'd1);
    expectCpl(7'd32, 5'd12, 64'h3333);
    fillOp(4'd3, 64'h3333);
    expectCpl(7'd33, 5'd13, 64'h4444);
    fillOp(4'd4, 64'h4444);

    // Store-buffer forwarding
    storeOp(64'h2000, 64'h55);
    checkOutput("stb_cmd", 64'(proc2mem_command), 64'd2);
    checkOutput("stb_addr", proc2mem_addr, 64'h2000);
    checkOutput("stb_data", proc2mem_data, 64'h55);
    expectCpl(7'd40, 5'd5, 64'h55);
    loadOp(64'h2000, 7'd40, 5'd5, 4'd0);
    checkOutput("fwd_cpl_latency", 64'(cdb_complete), 64'd1);
    checkOutput("fwd_no_load", 64'(proc2mem_command), 64'd2);
    respOp(4'd6);
    checkOutput("stb_drained_cmd", 64'(proc2mem_command), 64'd0);

    // Store merged into an outstanding miss
    loadOp(64'h3000, 7'd41, 5'd6, 4'd0);
    checkOutput("merge_load_addr", proc2mem_addr, 64'h3000);
    respOp(4'd7);
    storeOp(64'h3000, 64'h77);
    checkOutput("merge_store_cmd", 64'(proc2mem_command), 64'd2);
    checkOutput("merge_store_data", proc2mem_data, 64'h77);
    checkOutput("merge_no_cpl", 64'(cdb_complete), 64'd0);
    respOp(4'd8);
    expectCpl(7'd41, 5'd6, 64'h77);
    fillOp(4'd7, 64'h11);
    expectCpl(7'd42, 5'd7, 64'h77);
    loadOp(64'h3000, 7'd42, 5'd7, 4'd0);
    checkOutput("merge_hit_no_mem", 64'(proc2mem_command), 64'd0);

    // Fill and hit completing in the same cycle
    loadOp(64'h5000, 7'd50, 5'd8, 4'd0);
    checkOutput("pair_miss_addr", proc2mem_addr, 64'h5000);
    respOp(4'd9);
    expectCpl(7'd50, 5'd8, 64'h5555);
    expectCpl(7'd51, 5'd9, 64'h2222);
    applyStimulus(1'b1, 64'h4008, 7'd51, 5'd9, 1'b0, 64'd0, 64'd0, 4'd0, 4'd9, 64'h5555);
    checkOutput("pair_first_pr", 64'(cdb_prf_pr_idx), 64'd50);
    respOp(4'd0);
    checkOutput("pair_second_pr", 64'(cdb_prf_pr_idx), 64'd51);
    respOp(4'd0);

    // Reset with two fills outstanding
    loadOp(64'h6000, 7'd60, 5'd14, 4'd0);
    checkOutput("rst_load0_addr", proc2mem_addr, 64'h6000);
    loadOp(64'h7008, 7'd61, 5'd15, 4'd10);
    checkOutput("rst_load1_addr", proc2mem_addr, 64'h7008);
    respOp(4'd11);
    checkOutput("rst_pending_cmd", 64'(proc2mem_command), 64'd0);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_avail", 64'(Dcache_avail), 64'd1);
    checkOutput("midrst_cdb", 64'(cdb_complete), 64'd0);
    checkOutput("midrst_cmd", 64'(proc2mem_command), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    fillOp(4'd10, 64'hDEAD);
    checkOutput("stale_fill10_cdb", 64'(cdb_complete), 64'd0);
    fillOp(4'd11, 64'hBEEF);
    checkOutput("stale_fill11_cdb", 64'(cdb_complete), 64'd0);
    loadOp(64'h4008, 7'd62, 5'd1, 4'd0);
    checkOutput("post_rst_miss_cdb", 64'(cdb_complete), 64'd0);
    checkOutput("post_rst_miss_cmd", 64'(proc2mem_command), 64'd1);
    checkOutput("post_rst_miss_addr", proc2mem_addr, 64'h4008);
    respOp(4'd0);
    respOp(4'd0);

    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
